// File: rtl/cbc_dec_seq.sv
// Sequencer for a combinational AES-128 CBC decryption core: feeds ciphertext blocks,
// waits a multicycle settle window, returns plaintext and owns the CBC chaining IV.
// Optional block counter enabled with `define CBC_BLKCNT_EN (otherwise blk_cnt is tied to 0).
//
// state   | meaning
// IDLE    | no message; key/iv latched on start
// WAIT_CT | ct_ready high, waiting for the next ciphertext block
// SETTLE  | core inputs held while the combinational core settles
// OUT     | pt_valid high until the sink takes the plaintext block
module cbc_dec_seq #(
  parameter int SETTLE_CYCLES = 4,
  parameter int BLKCNT_W      = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [127:0]        key_in,
  input  logic [127:0]        iv_in,
  input  logic                abort,
  input  logic                ct_valid,
  output logic                ct_ready,
  input  logic [127:0]        ct_data,
  input  logic                ct_last,
  output logic                pt_valid,
  input  logic                pt_ready,
  output logic [127:0]        pt_data,
  output logic                pt_last,
  output logic                busy,
  output logic [127:0]        core_image,
  output logic [127:0]        core_key,
  output logic [127:0]        core_iv,
  input  logic [127:0]        core_planetext,
  output logic [BLKCNT_W-1:0] blk_cnt
);

  typedef enum logic [1:0] {IDLE, WAIT_CT, SETTLE, OUT} state_t;

  state_t     state;
  logic [3:0] settle_cnt;
  logic       last_q;

`ifndef CBC_BLKCNT_EN
  assign blk_cnt = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      settle_cnt <= '0;
      last_q     <= 1'b0;
      ct_ready   <= 1'b0;
      pt_valid   <= 1'b0;
      pt_data    <= '0;
      pt_last    <= 1'b0;
      busy       <= 1'b0;
      core_image <= '0;
      core_key   <= '0;
      core_iv    <= '0;
`ifdef CBC_BLKCNT_EN
      blk_cnt    <= '0;
`endif
    end else if (abort && state != IDLE) begin
      // abort wins over any coincident handshake; blk_cnt keeps its value
      state    <= IDLE;
      last_q   <= 1'b0;
      ct_ready <= 1'b0;
      pt_valid <= 1'b0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            core_key <= key_in;
            core_iv  <= iv_in;
`ifdef CBC_BLKCNT_EN
            blk_cnt  <= '0;
`endif
            state    <= WAIT_CT;
            ct_ready <= 1'b1;
            busy     <= 1'b1;
          end
        end
        WAIT_CT: begin
          if (ct_valid) begin
            core_image <= ct_data;
            last_q     <= ct_last;
            settle_cnt <= 4'(SETTLE_CYCLES);
`ifdef CBC_BLKCNT_EN
            blk_cnt    <= blk_cnt + 1'b1;
`endif
            state      <= SETTLE;
            ct_ready   <= 1'b0;
          end
        end
        SETTLE: begin
          // core has seen stable inputs for SETTLE_CYCLES edges once the count is exhausted
          if (settle_cnt == 4'd0) begin
            pt_data  <= core_planetext;
            pt_last  <= last_q;
            core_iv  <= core_image;
            state    <= OUT;
            pt_valid <= 1'b1;
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end
        OUT: begin
          if (pt_ready) begin
            pt_valid <= 1'b0;
            if (pt_last) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state    <= WAIT_CT;
              ct_ready <= 1'b1;
            end
          end
        end
        default: begin
          state    <= IDLE;
          ct_ready <= 1'b0;
          pt_valid <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule
